mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Multi-cycle 16-bit multiply/divide execute unit. Consumes the two register-file read operands
//  and produces a 32-bit result as two halves: low/quotient to the destination register,
//  high/remainder to R0 via the file's secondary write port.
//  Drives regDst, regDstData, regR15Data, wr and wrR15 of the register file directly.
//  Stalls the pipeline through busy.
// PARAMETERS
//  dataSize  16  operand and result-half width
//  regSize   4   register index width
// PORTS
//  clk         in   1         clock, all state updates on rising edge
//  rst         in   1         synchronous reset, active-high
//  start       in   1         request; sampled only in IDLE
//  op          in   2         00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed)
//  opA         in   dataSize  multiplicand / dividend (rdR1)
//  opB         in   dataSize  multiplier / divisor (rdR2)
//  dstIn       in   regSize   destination register index, captured with start
//  busy        out  1         unit occupied; pipeline must hold
//  done        out  1         one-cycle pulse, result valid
//  divZero     out  1         with done: divide by zero occurred
//  regDst      out  regSize   to register file regDst
//  regDstData  out  dataSize  low product / quotient
//  regR15Data  out  dataSize  high product / remainder
//  wr          out  1         to register file wr
//  wrR15       out  1         to register file wrR15
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE. rst mid-operation discards the operation; no write issued.
//  FSM: IDLE -> PREP -> CALC(x16) -> DONE -> IDLE.
//  - IDLE: if start, latch op, opA, opB and dstIn, then go to PREP.
//    start in any other state is ignored; no queueing.
//  - PREP: signed ops take magnitudes and record signs (sA, sB). Load the 16-bit iteration counter.
//    For a divide with opB==0, go directly to DONE.
//  - CALC: 16 cycles.
//    - Multiply: shift-add, one multiplier bit per cycle.
//    - Divide: restoring, one quotient bit per cycle.
//  - DONE: one cycle. Apply signs:
//    - Product is negated if sA^sB.
//    - Quotient is negated if sA^sB.
//    - Remainder is negated if sA.
//  Output timing: busy is high from the cycle after start is accepted through DONE inclusive.
//  - Normal ops: start at cycle 0; done, wr, wrR15 high at cycle 18; busy low and new start accepted at cycle 19.
//  - Divide by zero: done at cycle 2.
//  Divide by zero results: regDstData=16'hFFFF, regR15Data=opA unmodified, divZero=1.
//  -32768 / -1 (DIV): quotient 16'h8000 (wraps), remainder 0, divZero=0.
//  Multiply with signed operand 16'h8000 gives an exact 32-bit product (magnitude fits in 16 bits unsigned).
//  R0 collision: if dstIn==0, assert wr only, with wrR15=0; R0 receives the low/quotient half.
//  wr, wrR15, done and divZero are registered and 0 outside DONE.
//  regDst, regDstData and regR15Data hold the last result until the next DONE or rst.
// TESTING
//  MULU 16'h00FF*16'h0101, dst=3 -> cycle 18: regDstData=FFFF, regR15Data=0000, regDst=3, wr=wrR15=1.
//  MUL 16'hFFFF*16'h0050 -> regDstData=FFB0, regR15Data=FFFF.
//  DIVU 16'hF033/16'h0050 -> regDstData=0300, regR15Data=0033, divZero=0.
//  DIV 16'hFFB0/16'h0003 -> regDstData=FFE6 (-26), regR15Data=FFFE (-2).
//  DIVU 16'h1234/16'h0000 -> done at cycle 2: regDstData=FFFF, regR15Data=1234, divZero=1.
//  Combined sequence, each check in order:
//  - MULU with dst=0 -> wr=1, wrR15=0.
//  - Second start pulse at cycle 5 -> ignored.
//  - rst at cycle 8 -> no done or wr, busy=0 next cycle.
//  - Next start -> normal 18-cycle latency.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle 16-bit multiply/divide execute unit: shift-add multiply, restoring divide,
// sign fix-up on completion, and direct drive of the register file's two write ports.
module mul_div_unit #(
  parameter int unsigned dataSize = 16,
  parameter int unsigned regSize  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [dataSize-1:0] opA,
  input  logic [dataSize-1:0] opB,
  input  logic [regSize-1:0]  dstIn,
  output logic                busy,
  output logic                done,
  output logic                divZero,
  output logic [regSize-1:0]  regDst,
  output logic [dataSize-1:0] regDstData,
  output logic [dataSize-1:0] regR15Data,
  output logic                wr,
  output logic                wrR15
);

  localparam int unsigned DW = dataSize;
  localparam int unsigned CW = $clog2(dataSize);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d;
  logic [DW-1:0]       a_q, a_d;
  logic [DW-1:0]       b_q, b_d;
  logic [regSize-1:0]  dst_q, dst_d;
  logic                sa_q, sa_d;
  logic                sb_q, sb_d;
  logic [DW-1:0]       hi_q, hi_d;
  logic [DW-1:0]       lo_q, lo_d;
  logic [DW-1:0]       m_q, m_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                done_q, done_d;
  logic                dz_q, dz_d;
  logic                wr_q, wr_d;
  logic                wr15_q, wr15_d;
  logic [regSize-1:0]  rdst_q, rdst_d;
  logic [DW-1:0]       rlo_q, rlo_d;
  logic [DW-1:0]       rhi_q, rhi_d;

  logic                is_div;
  logic                sgn_a, sgn_b;
  logic [DW-1:0]       mag_a, mag_b;
  logic [DW:0]         mul_sum;
  logic [DW:0]         div_rsh;
  logic [DW+1:0]       div_diff;
  logic [DW-1:0]       step_hi, step_lo;
  logic [2*DW-1:0]     prod, prod_s;
  logic [DW-1:0]       res_lo, res_hi;

  assign is_div = op_q[1];
  assign sgn_a  = op_q[0] & a_q[DW-1];
  assign sgn_b  = op_q[0] & b_q[DW-1];
  assign mag_a  = sgn_a ? -a_q : a_q;
  assign mag_b  = sgn_b ? -b_q : b_q;

  // One iteration of either algorithm; hi holds partial product / partial remainder,
  // lo holds the remaining multiplier bits / dividend bits being shifted into quotient.
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(DW+1){1'b0}});
    div_rsh  = {hi_q, lo_q[DW-1]};
    div_diff = {1'b0, div_rsh} - {2'b00, m_q};
    if (is_div) begin
      step_hi = div_diff[DW+1] ? div_rsh[DW-1:0] : div_diff[DW-1:0];
      step_lo = {lo_q[DW-2:0], ~div_diff[DW+1]};
    end else begin
      step_hi = mul_sum[DW:1];
      step_lo = {mul_sum[0], lo_q[DW-1:1]};
    end
  end

  // Sign fix-up is applied to the final iteration's outputs so the result lands in DONE.
  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = (sa_q ^ sb_q) ? -prod : prod;
    if (is_div) begin
      res_lo = (sa_q ^ sb_q) ? -step_lo : step_lo;
      res_hi = sa_q ? -step_hi : step_hi;
    end else begin
      res_lo = prod_s[DW-1:0];
      res_hi = prod_s[2*DW-1:DW];
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    wr_d    = 1'b0;
    wr15_d  = 1'b0;
    rdst_d  = rdst_q;
    rlo_d   = rlo_q;
    rhi_d   = rhi_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = opA;
          b_d     = opB;
          dst_d   = dstIn;
          state_d = PREP;
        end
      end
      PREP: begin
        sa_d  = sgn_a;
        sb_d  = sgn_b;
        hi_d  = '0;
        cnt_d = CW'(DW - 1);
        lo_d  = is_div ? mag_a : mag_b;
        m_d   = is_div ? mag_b : mag_a;
        if (is_div && (b_q == '0)) begin
          state_d = DONE;
          done_d  = 1'b1;
          dz_d    = 1'b1;
          wr_d    = 1'b1;
          wr15_d  = (dst_q != '0);
          rdst_d  = dst_q;
          rlo_d   = '1;
          rhi_d   = a_q;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          wr_d    = 1'b1;
          wr15_d  = (dst_q != '0);
          rdst_d  = dst_q;
          rlo_d   = res_lo;
          rhi_d   = res_hi;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      wr_q    <= 1'b0;
      wr15_q  <= 1'b0;
      rdst_q  <= '0;
      rlo_q   <= '0;
      rhi_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      wr_q    <= wr_d;
      wr15_q  <= wr15_d;
      rdst_q  <= rdst_d;
      rlo_q   <= rlo_d;
      rhi_q   <= rhi_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign divZero    = dz_q;
  assign wr         = wr_q;
  assign wrR15      = wr15_q;
  assign regDst     = rdst_q;
  assign regDstData = rlo_q;
  assign regR15Data = rhi_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors with hand-computed results,
// checked by a monitor whenever the unit pulses done.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] opA, opB;
  logic [3:0]  dstIn;
  logic        busy, done, divZero, wr, wrR15;
  logic [3:0]  regDst;
  logic [15:0] regDstData, regR15Data;

  mul_div_unit #(.dataSize(16), .regSize(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opA(opA), .opB(opB), .dstIn(dstIn),
    .busy(busy), .done(done), .divZero(divZero), .regDst(regDst),
    .regDstData(regDstData), .regR15Data(regR15Data), .wr(wr), .wrR15(wrR15)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [3:0]  dst;
    logic [15:0] lo;
    logic [15:0] hi;
    logic        wr15;
    logic        dz;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cyc;

  localparam logic [1:0] MULU = 2'b00, MUL = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, ".cycle"}, 32'(cyc), 32'(e.due));
          chk({e.name, ".regDst"}, 32'(regDst), 32'(e.dst));
          chk({e.name, ".regDstData"}, 32'(regDstData), 32'(e.lo));
          chk({e.name, ".regR15Data"}, 32'(regR15Data), 32'(e.hi));
          chk({e.name, ".wr"}, 32'(wr), 32'd1);
          chk({e.name, ".wrR15"}, 32'(wrR15), 32'(e.wr15));
          chk({e.name, ".divZero"}, 32'(divZero), 32'(e.dz));
          chk({e.name, ".busy"}, 32'(busy), 32'd1);
        end
      end else begin
        chk("strobes_idle", {29'd0, wr, wrR15, divZero}, 32'd0);
      end
    end
  endtask

  // Called right after a negedge; that cycle is cycle 0 of the operation.
  task automatic launch(input string nm, input logic [1:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] d, input logic [15:0] elo,
                        input logic [15:0] ehi, input logic ewr15, input logic edz,
                        input int lat, input bit push);
    exp_t e;
    start = 1'b1; op = o; opA = a; opB = b; dstIn = d;
    start_cyc = cyc;
    if (push) begin
      e.name = nm; e.dst = d; e.lo = elo; e.hi = ehi; e.wr15 = ewr15; e.dz = edz;
      e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0; opA = 16'h5A5A; opB = 16'hA5A5; dstIn = 4'hF;
    chk({nm, ".busy_c1"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_idle(input string nm, input int lat);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) chk({nm, ".timeout"}, 32'(busy), 32'd0);
    else      chk({nm, ".busy_drop"}, 32'(cyc - start_cyc), 32'(lat + 1));
  endtask

  task automatic run(input string nm, input logic [1:0] o, input logic [15:0] a,
                     input logic [15:0] b, input logic [3:0] d, input logic [15:0] elo,
                     input logic [15:0] ehi, input logic edz);
    int lat;
    lat = edz ? 2 : 18;
    launch(nm, o, a, b, d, elo, ehi, (d != 4'd0), edz, lat, 1'b1);
    wait_idle(nm, lat);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0; dstIn = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.strobes", {28'd0, done, wr, wrR15, divZero}, 32'd0);
    chk("reset.regDst", 32'(regDst), 32'd0);
    chk("reset.data", {regDstData, regR15Data}, 32'd0);
    rst = 1'b0;
    fork monitor(); join_none
    @(negedge clk);

    run("mulu_ff",    MULU, 16'h00FF, 16'h0101, 4'd3, 16'hFFFF, 16'h0000, 1'b0);
    run("mul_neg",    MUL,  16'hFFFF, 16'h0050, 4'd5, 16'hFFB0, 16'hFFFF, 1'b0);
    run("divu",       DIVU, 16'hF033, 16'h0050, 4'd9, 16'h0300, 16'h0033, 1'b0);
    run("div_neg",    DIV,  16'hFFB0, 16'h0003, 4'd2, 16'hFFE6, 16'hFFFE, 1'b0);
    run("divu_zero",  DIVU, 16'h1234, 16'h0000, 4'd4, 16'hFFFF, 16'h1234, 1'b1);
    run("div_zero_s", DIV,  16'h8000, 16'h0000, 4'd6, 16'hFFFF, 16'h8000, 1'b1);
    run("div_wrap",   DIV,  16'h8000, 16'hFFFF, 4'd1, 16'h8000, 16'h0000, 1'b0);
    run("mul_min2",   MUL,  16'h8000, 16'h8000, 4'd7, 16'h0000, 16'h4000, 1'b0);
    run("mul_min1",   MUL,  16'h8000, 16'h0001, 4'd8, 16'h8000, 16'hFFFF, 1'b0);
    run("div_pos_neg",DIV,  16'h0007, 16'hFFFE, 4'd10, 16'hFFFD, 16'h0001, 1'b0);
    run("div_neg_pos",DIV,  16'hFFF9, 16'h0002, 4'd11, 16'hFFFD, 16'hFFFF, 1'b0);
    run("mulu_max",   MULU, 16'hFFFF, 16'hFFFF, 4'd12, 16'h0001, 16'hFFFE, 1'b0);

    // R0 collision, with a second start at cycle 5 that must be dropped
    launch("r0", MULU, 16'h0003, 16'h0005, 4'd0, 16'h000F, 16'h0000, 1'b0, 1'b0, 18, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; op = DIVU; opA = 16'h0100; opB = 16'h0002; dstIn = 4'd13;
    @(negedge clk);
    start = 1'b0;
    wait_idle("r0", 18);
    @(negedge clk);
    chk("no_queue.busy", 32'(busy), 32'd0);

    // Reset at cycle 8 of an operation discards it
    launch("rst_op", MUL, 16'h0102, 16'h0304, 4'd14, 16'h0, 16'h0, 1'b1, 1'b0, 18, 1'b0);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.strobes", {30'd0, done, wr}, 32'd0);
    chk("rst_mid.data", {regDstData, regR15Data}, 32'd0);
    repeat (20) @(negedge clk);
    chk("rst_mid.still_idle", 32'(busy), 32'd0);

    run("after_rst",  DIVU, 16'h0064, 16'h0007, 4'd15, 16'h000E, 16'h0002, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
